dram_port_arbiter: RTL

//  Shares the single-port distributed DRAM (async read, sync write) between two requesters:

---
 rtl/dram_port_arbiter.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/dram_port_arbiter.sv
// dram_port_arbiter
// Two-port front end for a single-port distributed DRAM (async read, sync write).
// Port 0 is the CPU data port and port 1 is the loader/DMA port.
// The block grants one request at a time and latches it. Loads and word stores take
// one DRAM access. Byte and half stores run as a read-modify-write over two cycles.
// A new grant is never issued while an ack pulse is showing.

module dram_port_arbiter #(
    parameter int ADDR_W   = 18,
    parameter bit RR_EN    = 1'b1,
    parameter bit PRIO_RST = 1'b0
) (
    input  logic              clk,
    input  logic              fpga_rst,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [1:0]        m0_mask,
    input  logic [31:0]       m0_wdata,
    output logic              m0_gnt,
    output logic              m0_ack,
    output logic [31:0]       m0_rdata,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [1:0]        m1_mask,
    input  logic [31:0]       m1_wdata,
    output logic              m1_gnt,
    output logic              m1_ack,
    output logic [31:0]       m1_rdata,

    output logic [ADDR_W-3:0] dram_a,
    output logic              dram_we,
    output logic [31:0]       dram_d,
    input  logic [31:0]       dram_spo,

    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACCESS   = 2'd1,
        ST_MERGE_WR = 2'd2
    } state_t;

    localparam logic [1:0] MASK_BYTE = 2'b00;
    localparam logic [1:0] MASK_HALF = 2'b01;
    localparam logic [1:0] MASK_WORD = 2'b10;

    state_t            state;
    state_t            state_nxt;

    // Latched request
    logic              own_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        mask_q;
    logic [31:0]       wdata_q;

    logic [31:0]       merge_q;
    logic              last_q;

    logic              grant_ok;
    logic              pick1;
    logic              sub_store;
    logic              done;

    // Pick out the addressed lane of a DRAM word, zero-extended.
    function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                                 input logic [1:0]  a,
                                                 input logic [1:0]  mask);
        logic [31:0] sh;
        sh = word >> {a, 3'b000};
        case (mask)
            MASK_BYTE: lane_extract = {24'h0, sh[7:0]};
            MASK_HALF: lane_extract = a[1] ? {16'h0, word[31:16]} : {16'h0, word[15:0]};
            MASK_WORD: lane_extract = word;
            default:   lane_extract = 32'h0;
        endcase
    endfunction

    // Replace the addressed byte/half lane of a DRAM word with right-aligned store data.
    function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                               input logic [31:0] wdata,
                                               input logic [1:0]  a,
                                               input logic [1:0]  mask);
        logic [31:0] r;
        r = word;
        if (mask == MASK_BYTE) begin
            r[{a, 3'b000} +: 8] = wdata[7:0];
        end else begin
            r[{a[1], 4'b0000} +: 16] = wdata[15:0];
        end
        lane_merge = r;
    endfunction

    // Arbitration: a lone requester wins; on contention round-robin or port 0 first.
    assign grant_ok  = (state == ST_IDLE) && !fpga_rst && !m0_ack && !m1_ack;
    assign pick1     = m1_req && (!m0_req || (RR_EN && !last_q));
    assign m0_gnt    = grant_ok && m0_req && !pick1;
    assign m1_gnt    = grant_ok && pick1;

    assign sub_store = we_q && !mask_q[1];
    assign done      = ((state == ST_ACCESS) && !sub_store) || (state == ST_MERGE_WR);

    // State register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples
        // the pre-edge values regardless of block ordering.
        if (fpga_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        // NOTE: default assignment first so no path through the case leaves state_nxt
        // unassigned, which would infer a latch.
        state_nxt = state;
        case (state)
            ST_IDLE:     if (m0_gnt || m1_gnt) state_nxt = ST_ACCESS;
            ST_ACCESS:   state_nxt = sub_store ? ST_MERGE_WR : ST_IDLE;
            ST_MERGE_WR: state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    // DRAM-side outputs and busy flag
    always_comb begin
        dram_a  = '0;
        dram_we = 1'b0;
        dram_d  = 32'h0;
        busy    = (state != ST_IDLE);
        case (state)
            ST_ACCESS: begin
                dram_a = addr_q[ADDR_W-1:2];
                if (we_q && mask_q[1]) begin
                    dram_we = 1'b1;
                    dram_d  = wdata_q;
                end
            end
            ST_MERGE_WR: begin
                dram_a  = addr_q[ADDR_W-1:2];
                dram_we = 1'b1;
                dram_d  = merge_q;
            end
            default: ;
        endcase
    end

    // Latch the granted request and remember which port won
    always_ff @(posedge clk) begin
        if (fpga_rst) begin
            own_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            mask_q  <= 2'b00;
            wdata_q <= 32'h0;
            last_q  <= !PRIO_RST;
        end else if (m0_gnt) begin
            own_q   <= 1'b0;
            we_q    <= m0_we;
            addr_q  <= m0_addr;
            mask_q  <= m0_mask;
            wdata_q <= m0_wdata;
            last_q  <= 1'b0;
        end else if (m1_gnt) begin
            own_q   <= 1'b1;
            we_q    <= m1_we;
            addr_q  <= m1_addr;
            mask_q  <= m1_mask;
            wdata_q <= m1_wdata;
            last_q  <= 1'b1;
        end
    end

    // Build the merged word for byte/half stores from the read data
    always_ff @(posedge clk) begin
        if (fpga_rst) begin
            merge_q <= 32'h0;
        end else if ((state == ST_ACCESS) && sub_store) begin
            merge_q <= lane_merge(dram_spo, wdata_q, addr_q[1:0], mask_q);
        end
    end

    // Completion pulse and load data, delivered only to the owner
    always_ff @(posedge clk) begin
        if (fpga_rst) begin
            m0_ack   <= 1'b0;
            m1_ack   <= 1'b0;
            m0_rdata <= 32'h0;
            m1_rdata <= 32'h0;
        end else begin
            m0_ack <= done && !own_q;
            m1_ack <= done && own_q;
            if ((state == ST_ACCESS) && !we_q) begin
                if (own_q) begin
                    m1_rdata <= lane_extract(dram_spo, addr_q[1:0], mask_q);
                end else begin
                    m0_rdata <= lane_extract(dram_spo, addr_q[1:0], mask_q);
                end
            end
        end
    end

endmodule
